alu_cmd_sequencer: RTL and testbench

Front-end stage for the 8-bit combinational ALU. It takes a byte stream of 3-byte commands (opcode/tag, operand A, operand B) over a valid/ready handshake and drives registered operands and mode into the ALU. It captures the ALU result and carry one cycle later and presents them, with the command tag, on a valid/ready result port. Only one command is in flight at a time.

---
 rtl/alu_cmd_sequencer.sv | 110 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// alu_cmd_sequencer : 3-byte command front end and result capture for the ALU
// Rev 1.0
// =============================================================================
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 4,
    parameter int TAG_WIDTH  = DATA_WIDTH - MODE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [MODE_WIDTH-1:0] alu_mode,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_cout,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_cout,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            cmd_count
);

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [TAG_WIDTH-1:0] r_tag;

    // Handshake outputs depend on the state register only.
    assign in_ready  = (r_state == S_OP) || (r_state == S_A) || (r_state == S_B);
    assign res_valid = (r_state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_OP;
        end else begin
            case (r_state)
                S_OP:    if (in_valid)  w_next_state = S_A;
                S_A:     if (in_valid)  w_next_state = S_B;
                S_B:     if (in_valid)  w_next_state = S_EXEC;
                S_EXEC:                 w_next_state = S_RESP;
                S_RESP:  if (res_ready) w_next_state = S_OP;
                default:                w_next_state = S_OP;
            endcase
        end
    end

    // Flush suppresses every register write in its cycle, including the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            r_tag     <= '0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_tag   <= '0;
            cmd_count <= 8'd0;
        end else if (!flush) begin
            case (r_state)
                S_OP: begin
                    if (in_valid) begin
                        alu_mode <= in_data[MODE_WIDTH-1:0];
                        r_tag    <= in_data[DATA_WIDTH-1:MODE_WIDTH];
                    end
                end
                S_A: begin
                    if (in_valid) alu_a <= in_data;
                end
                S_B: begin
                    if (in_valid) alu_b <= in_data;
                end
                S_EXEC: begin
                    res_data <= alu_result;
                    res_cout <= alu_cout;
                    res_tag  <= r_tag;
                end
                S_RESP: begin
                    if (res_ready) cmd_count <= cmd_count + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// tb_alu_cmd_sequencer : scoreboard bench for alu_cmd_sequencer with adder ALU
// Rev 1.0
// =============================================================================
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_mode;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic [7:0] res_data;
    logic       res_cout;
    logic [3:0] res_tag;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] cmd_count;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic [3:0] tag;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         tests_run;
    int         fails;
    logic [7:0] exp_count;

    alu_cmd_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .res_data   (res_data),
        .res_cout   (res_cout),
        .res_tag    (res_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .cmd_count  (cmd_count)
    );

    logic [8:0] w_sum;
    assign w_sum      = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = w_sum[7:0];
    assign alu_cout   = w_sum[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input int gap);
        logic [8:0] s;
        exp_t       x;
        s      = {1'b0, a} + {1'b0, b};
        x.data = s[7:0];
        x.cout = s[8];
        x.tag  = op[7:4];
        sb.push_back(x);
        send_byte(op);
        send_byte(a);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        send_byte(b);
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (res_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pop_exp();
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_mode, res_data, res_cout, res_tag, res_valid, cmd_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: a=%h b=%h mode=%h data=%h cout=%b tag=%h valid=%b cnt=%h, want all 0",
                     alu_a, alu_b, alu_mode, res_data, res_cout, res_tag, res_valid, cmd_count);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        res_ready = 1'b1;
        send_cmd(8'h30, 8'hF0, 8'h20, 0);
        tests_run++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_exec: res_valid=%b in_ready=%b want 0/0", res_valid, in_ready);
        end
        @(posedge clk);
        #1;
        pop_exp();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== e.data || res_cout !== e.cout || res_tag !== e.tag) begin
            fails++;
            $display("FAIL basic_result: valid=%b data=%h cout=%b tag=%h want 1 %h %b %h",
                     res_valid, res_data, res_cout, res_tag, e.data, e.cout, e.tag);
        end
        tests_run++;
        if (alu_mode !== 4'h0 || alu_a !== 8'hF0 || alu_b !== 8'h20) begin
            fails++;
            $display("FAIL basic_operands: mode=%h a=%h b=%h want 0 f0 20", alu_mode, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        exp_count = exp_count + 8'd1;
        tests_run++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || cmd_count !== exp_count) begin
            fails++;
            $display("FAIL basic_consume: valid=%b in_ready=%b cnt=%h want 0 1 %h",
                     res_valid, in_ready, cmd_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        res_ready = 1'b0;
        send_cmd(8'h30, 8'hF0, 8'h20, 0);
        wait_res(ok);
        pop_exp();
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_timeout: res_valid=%b want 1", res_valid);
        end
        bad = 1'b0;
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== e.data ||
                res_cout !== e.cout || res_tag !== e.tag || alu_a !== 8'hF0) bad = 1'b1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL bp_hold: valid=%b in_ready=%b data=%h a=%h want 1 0 %h f0",
                     res_valid, in_ready, res_data, alu_a, e.data);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_count = exp_count + 8'd1;
        tests_run++;
        if (cmd_count !== exp_count || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: cnt=%h in_ready=%b want %h 1", cmd_count, in_ready, exp_count);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        res_ready = 1'b1;
        send_cmd(8'h5C, 8'h01, 8'h02, 4);
        wait_res(ok);
        pop_exp();
        tests_run++;
        if (!ok || res_data !== e.data || res_cout !== e.cout || res_tag !== e.tag || alu_mode !== 4'hC) begin
            fails++;
            $display("FAIL gaps_result: ok=%b data=%h cout=%b tag=%h mode=%h want 1 %h %b %h c",
                     ok, res_data, res_cout, res_tag, alu_mode, e.data, e.cout, e.tag);
        end
        @(posedge clk);
        #1;
        exp_count = exp_count + 8'd1;
        tests_run++;
        if (cmd_count !== exp_count) begin
            fails++;
            $display("FAIL gaps_count: got %h want %h", cmd_count, exp_count);
        end
    endtask

    task automatic test_flush_b();
        bit ok;
        res_ready = 1'b1;
        send_byte(8'h9A);
        send_byte(8'h44);
        in_data  = 8'h77;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || alu_b !== 8'h02 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_b_drop: in_ready=%b b=%h valid=%b want 1 02 0", in_ready, alu_b, res_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (res_valid !== 1'b0 || cmd_count !== exp_count) begin
            fails++;
            $display("FAIL flush_b_noresult: valid=%b cnt=%h want 0 %h", res_valid, cmd_count, exp_count);
        end
        send_cmd(8'h00, 8'h01, 8'h01, 0);
        wait_res(ok);
        pop_exp();
        tests_run++;
        if (!ok || res_data !== e.data || res_tag !== e.tag || alu_mode !== 4'h0) begin
            fails++;
            $display("FAIL flush_b_next: ok=%b data=%h tag=%h mode=%h want 1 %h %h 0",
                     ok, res_data, res_tag, alu_mode, e.data, e.tag);
        end
        @(posedge clk);
        #1;
        exp_count = exp_count + 8'd1;
        tests_run++;
        if (cmd_count !== exp_count) begin
            fails++;
            $display("FAIL flush_b_count: got %h want %h", cmd_count, exp_count);
        end
    endtask

    task automatic test_flush_resp();
        bit ok;
        res_ready = 1'b0;
        send_cmd(8'h21, 8'h10, 8'h20, 0);
        wait_res(ok);
        pop_exp();
        res_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        tests_run++;
        if (!ok || res_valid !== 1'b0 || in_ready !== 1'b1 || cmd_count !== exp_count) begin
            fails++;
            $display("FAIL flush_resp: ok=%b valid=%b in_ready=%b cnt=%h want 1 0 1 %h",
                     ok, res_valid, in_ready, cmd_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int n;
        int bad;
        res_ready = 1'b1;
        n   = 256 - int'(exp_count);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            send_cmd(8'($urandom), 8'($urandom), 8'($urandom), 0);
            wait_res(ok);
            pop_exp();
            if (!ok || res_data !== e.data || res_cout !== e.cout || res_tag !== e.tag) bad++;
            @(posedge clk);
            #1;
            exp_count = exp_count + 8'd1;
            if (cmd_count !== exp_count) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wrap_results: %0d bad results/counts out of %0d commands", bad, n);
        end
        tests_run++;
        if (cmd_count !== 8'h00) begin
            fails++;
            $display("FAIL wrap_count: got %h want 00", cmd_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_byte(8'h12);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_mode, res_data, res_cout, res_tag, res_valid, cmd_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: a=%h b=%h mode=%h data=%h cout=%b tag=%h valid=%b cnt=%h, want all 0",
                     alu_a, alu_b, alu_mode, res_data, res_cout, res_tag, res_valid, cmd_count);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_count = 8'd0;
        sb.delete();
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
        res_ready = 1'b1;
        send_cmd(8'h47, 8'h80, 8'h81, 0);
        wait_res(ok);
        pop_exp();
        tests_run++;
        if (!ok || res_data !== e.data || res_cout !== e.cout || res_tag !== e.tag) begin
            fails++;
            $display("FAIL reset_mid_next: ok=%b data=%h cout=%b tag=%h want 1 %h %b %h",
                     ok, res_data, res_cout, res_tag, e.data, e.cout, e.tag);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (cmd_count !== 8'h01) begin
            fails++;
            $display("FAIL reset_mid_count: got %h want 01", cmd_count);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        exp_count = 8'd0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_flush_b();
        test_flush_resp();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
